// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the LEGv8 ID-stage immediate generator.
// Pure declarations, no logic.
package imm_pkg;

  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_D     = 3'd2,
    FMT_CB    = 3'd3,
    FMT_B     = 3'd4,
    FMT_SHIFT = 3'd5
  } imm_fmt_t;

  // B format, opcode in [31:26]
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;

  // CB format, opcode in [31:24]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  // D format, opcode in [31:21]
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;

  // I format, opcode in [31:22]
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
  localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
  localparam logic [9:0]  OP_EORI  = 10'b1101001000;

  // Shift-immediate (R format with shamt), opcode in [31:21]
  localparam logic [10:0] OP_LSL   = 11'b11010011011;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;

endpackage

// File: rtl/imm_decode.sv
// Combinational LEGv8 immediate classifier and extender (instr -> imm, fmt).
// Zero latency; no handshake, purely combinational.
module imm_decode
  import imm_pkg::*;
(
  input  logic [INSTR_W-1:0] in_instr,
  output logic [DATA_W-1:0]  imm,
  output imm_fmt_t           fmt
);

  logic [5:0]  op6;
  logic [7:0]  op8;
  logic [9:0]  op10;
  logic [10:0] op11;

  assign op6  = in_instr[31:26];
  assign op8  = in_instr[31:24];
  assign op10 = in_instr[31:22];
  assign op11 = in_instr[31:21];

  // First match wins; branch offsets are word counts, hence the <<2.
  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    if (op6 == OP_B || op6 == OP_BL) begin
      fmt = FMT_B;
      imm = {{(DATA_W-26){in_instr[25]}}, in_instr[25:0]} << 2;
    end else if (op8 inside {OP_CBZ, OP_CBNZ, OP_BCOND}) begin
      fmt = FMT_CB;
      imm = {{(DATA_W-19){in_instr[23]}}, in_instr[23:5]} << 2;
    end else if (op11 inside {OP_LDUR, OP_STUR}) begin
      fmt = FMT_D;
      imm = {{(DATA_W-9){in_instr[20]}}, in_instr[20:12]};
    end else if (op10 inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                              OP_ANDI, OP_ORRI, OP_EORI}) begin
      fmt = FMT_I;
      imm = {{(DATA_W-12){1'b0}}, in_instr[21:10]};
    end else if (op11 inside {OP_LSL, OP_LSR}) begin
      fmt = FMT_SHIFT;
      imm = {{(DATA_W-6){1'b0}}, in_instr[15:10]};
    end
  end

endmodule

// File: rtl/imm_stage.sv
// ID-stage immediate generator with registered ID/EX valid/ready hand-off.
// Latency 1 cycle; 2-entry (output + skid) buffer, in_ready comes straight from skid state.
module imm_stage
  import imm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_imm,
  output imm_fmt_t           out_fmt,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [DATA_W-1:0] dec_imm;
  imm_fmt_t          dec_fmt;
  logic [DATA_W-1:0] skid_imm;
  imm_fmt_t          skid_fmt;
  logic              skid_vld;
  logic              in_xfer;
  logic              out_free;

  imm_decode u_decode (
    .in_instr (in_instr),
    .imm      (dec_imm),
    .fmt      (dec_fmt)
  );

  assign in_ready = !skid_vld;
  assign in_xfer  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_imm   <= '0;
      out_fmt   <= FMT_NONE;
      out_valid <= 1'b0;
      skid_imm  <= '0;
      skid_fmt  <= FMT_NONE;
      skid_vld  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_vld  <= 1'b0;
    end else if (out_free) begin
      // Skid is older than anything arriving now, so it refills the output first.
      if (skid_vld) begin
        out_imm   <= skid_imm;
        out_fmt   <= skid_fmt;
        out_valid <= 1'b1;
        skid_vld  <= 1'b0;
      end else if (in_xfer) begin
        out_imm   <= dec_imm;
        out_fmt   <= dec_fmt;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_imm <= dec_imm;
      skid_fmt <= dec_fmt;
      skid_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_stage.sv
// Self-checking bench for imm_stage: directed decode/handshake scenarios plus a random scoreboard run.
module tb_imm_stage;
  import imm_pkg::*;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_imm;
  imm_fmt_t    out_fmt;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  localparam int NV = 10;
  logic [31:0] dir_instr [NV];
  exp_t        dir_exp   [NV];

  always #5 clk = ~clk;

  imm_stage dut (
    .clk       (clk),
    .reset     (rst_n),
    .flush     (flush),
    .in_instr  (in_instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_imm   (out_imm),
    .out_fmt   (out_fmt),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_tables();
    dir_instr[0] = 32'h913FFC41; dir_exp[0] = '{imm: 64'h0000000000000FFF, fmt: 3'd1}; // ADDI
    dir_instr[1] = 32'hF85F8020; dir_exp[1] = '{imm: 64'hFFFFFFFFFFFFFFF8, fmt: 3'd2}; // LDUR
    dir_instr[2] = 32'h17FFFFFF; dir_exp[2] = '{imm: 64'hFFFFFFFFFFFFFFFC, fmt: 3'd4}; // B
    dir_instr[3] = 32'hB4000020; dir_exp[3] = '{imm: 64'h0000000000000004, fmt: 3'd3}; // CBZ
    dir_instr[4] = 32'h00000000; dir_exp[4] = '{imm: 64'h0000000000000000, fmt: 3'd0}; // none
    dir_instr[5] = 32'hD360FC00; dir_exp[5] = '{imm: 64'h000000000000003F, fmt: 3'd5}; // LSL #63
    dir_instr[6] = 32'h54FFFFE0; dir_exp[6] = '{imm: 64'hFFFFFFFFFFFFFFFC, fmt: 3'd3}; // B.cond -1
    dir_instr[7] = 32'h95FFFFFF; dir_exp[7] = '{imm: 64'h0000000007FFFFFC, fmt: 3'd4}; // BL max +
    dir_instr[8] = 32'hB2200000; dir_exp[8] = '{imm: 64'h0000000000000800, fmt: 3'd1}; // ORRI msb
    dir_instr[9] = 32'hF8100000; dir_exp[9] = '{imm: 64'hFFFFFFFFFFFFFF00, fmt: 3'd2}; // STUR -256
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t   e;
    longint s;
    e.imm = 64'd0;
    e.fmt = 3'd0;
    if (ins[31:26] == 6'h05 || ins[31:26] == 6'h25) begin
      s = longint'($signed(ins[25:0]));
      e.imm = s * 4;
      e.fmt = 3'd4;
    end else if (ins[31:24] == 8'hB4 || ins[31:24] == 8'hB5 || ins[31:24] == 8'h54) begin
      s = longint'($signed(ins[23:5]));
      e.imm = s * 4;
      e.fmt = 3'd3;
    end else if (ins[31:21] == 11'h7C2 || ins[31:21] == 11'h7C0) begin
      s = longint'($signed(ins[20:12]));
      e.imm = s;
      e.fmt = 3'd2;
    end else if (ins[31:22] inside {10'h244, 10'h2C4, 10'h344, 10'h3C4, 10'h248, 10'h2C8, 10'h348}) begin
      e.imm = {52'd0, ins[21:10]};
      e.fmt = 3'd1;
    end else if (ins[31:21] == 11'h69B || ins[31:21] == 11'h69A) begin
      e.imm = {58'd0, ins[15:10]};
      e.fmt = 3'd5;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[31:26] = ($urandom_range(0, 1) != 0) ? 6'h05 : 6'h25;
      1: case ($urandom_range(0, 2))
           0: r[31:24] = 8'hB4;
           1: r[31:24] = 8'hB5;
           default: r[31:24] = 8'h54;
         endcase
      2: r[31:21] = ($urandom_range(0, 1) != 0) ? 11'h7C2 : 11'h7C0;
      3: case ($urandom_range(0, 6))
           0: r[31:22] = 10'h244;
           1: r[31:22] = 10'h2C4;
           2: r[31:22] = 10'h344;
           3: r[31:22] = 10'h3C4;
           4: r[31:22] = 10'h248;
           5: r[31:22] = 10'h2C8;
           default: r[31:22] = 10'h348;
         endcase
      4: r[31:21] = ($urandom_range(0, 1) != 0) ? 11'h69B : 11'h69A;
      default: ;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_imm !== 64'd0) begin errors++; $display("FAIL reset_out_imm: got %h want 0", out_imm); end
    checks++;
    if (out_fmt !== 3'd0) begin errors++; $display("FAIL reset_out_fmt: got %0d want 0", out_fmt); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = dir_instr[i];
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_imm !== dir_exp[i].imm || out_fmt !== dir_exp[i].fmt) begin
        errors++;
        $display("FAIL decode[%0d]: got v=%b imm=%h fmt=%0d want v=1 imm=%h fmt=%0d",
                 i, out_valid, out_imm, out_fmt, dir_exp[i].imm, dir_exp[i].fmt);
      end
    end
    in_valid = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL decode_idle: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_instr = dir_instr[k];
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_imm !== dir_exp[0].imm || out_fmt !== dir_exp[0].fmt) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b imm=%h want v=1 imm=%h", k, out_valid, out_imm, dir_exp[0].imm);
      end
      checks++;
      if (in_ready !== (k == 0)) begin
        errors++;
        $display("FAIL stall_in_ready[%0d]: got %b want %b", k, in_ready, (k == 0));
      end
    end
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_imm !== dir_exp[k].imm || out_fmt !== dir_exp[k].fmt) begin
        errors++;
        $display("FAIL drain_order[%0d]: got v=%b imm=%h fmt=%0d want v=1 imm=%h fmt=%0d",
                 k, out_valid, out_imm, out_fmt, dir_exp[k].imm, dir_exp[k].fmt);
      end
      if (k == 1) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready: got %b want 1", in_ready); end
      end
    end
    in_valid = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = dir_instr[0];
    cyc();
    in_instr  = dir_instr[1];
    cyc();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full: in_ready got %b want 0", in_ready); end
    flush    = 1'b1;
    in_instr = dir_instr[5];
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = dir_instr[7];
    cyc();
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== dir_exp[7].imm || out_fmt !== dir_exp[7].fmt) begin
      errors++;
      $display("FAIL flush_next: got v=%b imm=%h want v=1 imm=%h", out_valid, out_imm, dir_exp[7].imm);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_next_alone: out_valid got %b want 0", out_valid); end

    // Flush while an input transfer is possible: that input must vanish too.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = dir_instr[3];
    cyc();
    flush    = 1'b1;
    in_instr = dir_instr[4];
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_discard: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard_late: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = dir_instr[8];
    cyc();
    in_instr  = dir_instr[9];
    cyc();
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_imm !== 64'd0 || out_fmt !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: got v=%b imm=%h fmt=%0d rdy=%b want v=0 imm=0 fmt=0 rdy=1",
               out_valid, out_imm, out_fmt, in_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = dir_instr[6];
    cyc();
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== dir_exp[6].imm || out_fmt !== dir_exp[6].fmt) begin
      errors++;
      $display("FAIL midrst_resume: got v=%b imm=%h want v=1 imm=%h", out_valid, out_imm, dir_exp[6].imm);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_resume_alone: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic        prev_hold;
    logic [63:0] prev_imm;
    logic [2:0]  prev_fmt;
    logic        ix;
    logic        ox;
    int          p_in;
    int          p_out;
    exp_t        e;
    prev_hold = 1'b0;
    prev_imm  = '0;
    prev_fmt  = '0;
    p_in      = 2;
    p_out     = 2;
    sbq.delete();
    for (int c = 0; c < 12000; c++) begin
      if (c % 1000 == 0) begin
        p_in  = $urandom_range(1, 4);
        p_out = $urandom_range(1, 4);
      end
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_imm !== prev_imm || out_fmt !== prev_fmt) begin
          errors++;
          $display("FAIL rnd_stall_stable @%0d: got v=%b imm=%h fmt=%0d want v=1 imm=%h fmt=%0d",
                   c, out_valid, out_imm, out_fmt, prev_imm, prev_fmt);
        end
      end
      checks++;
      if (in_ready !== (sbq.size() < 2) || out_valid !== (sbq.size() > 0)) begin
        errors++;
        $display("FAIL rnd_occupancy @%0d: got v=%b rdy=%b want entries=%0d", c, out_valid, in_ready, sbq.size());
      end
      in_valid  = ($urandom_range(1, 4) <= p_in);
      out_ready = ($urandom_range(1, 4) <= p_out);
      flush     = ($urandom_range(0, 299) == 0);
      in_instr  = rand_instr();
      ix = in_valid && in_ready;
      ox = out_valid && out_ready;
      if (flush) begin
        sbq.delete();
      end else begin
        if (ox) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL rnd_spurious @%0d: got imm=%h with nothing expected", c, out_imm);
          end else begin
            e = sbq.pop_front();
            if (out_imm !== e.imm || out_fmt !== e.fmt) begin
              errors++;
              $display("FAIL rnd_data @%0d: got imm=%h fmt=%0d want imm=%h fmt=%0d", c, out_imm, out_fmt, e.imm, e.fmt);
            end
          end
        end
        if (ix) sbq.push_back(ref_decode(in_instr));
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_imm  = out_imm;
      prev_fmt  = out_fmt;
      cyc();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL rnd_drain_spurious: got imm=%h with nothing expected", out_imm);
        end else begin
          e = sbq.pop_front();
          if (out_imm !== e.imm || out_fmt !== e.fmt) begin
            errors++;
            $display("FAIL rnd_drain_data: got imm=%h fmt=%0d want imm=%h fmt=%0d", out_imm, out_fmt, e.imm, e.fmt);
          end
        end
      end
      cyc();
    end
    checks++;
    if (out_valid !== 1'b0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL rnd_final: got v=%b with %0d expected entries left, want v=0 and 0", out_valid, sbq.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    out_ready = 1'b0;
    load_tables();
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_stage.md
Name: imm_stage

Overview:
- ID-stage immediate generator plus registered ID/EX hand-off for the LEGv8 pipeline.
- Takes the fetched 32-bit instruction and classifies its immediate format. Extracts and extends the immediate to 64 bits: zero-extend for I-type and shamt, sign-extend for D, CB and B, with CB and B shifted left 2.
- Presents the result to the EX-stage ALUSrc/branch-target logic through a valid/ready handshake with a 2-entry skid buffer.

Parameters:
- DATA_W, 64, width of the extended immediate.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held entries (branch taken).
- in_instr  in  32  instruction from IF/ID.
- in_valid  in  1  in_instr valid.
- in_ready  out  1  stage can accept this cycle.
- out_imm  out  64  extended immediate.
- out_fmt  out  3  imm_fmt_t code of out_imm.
- out_valid  out  1  out_imm/out_fmt valid.
- out_ready  in  1  EX consumes this cycle.

Behaviour:
- Reset (reset=0, async): out_imm=0, out_fmt=FMT_NONE, out_valid=0, skid empty, in_ready=1. All outputs hold these values while reset is low.
- Decode uses first-match priority on the opcode fields:
  - B: [31:26] in {000101, 100101}. imm26=[25:0], sign-extended, then <<2.
  - CB: [31:24] in {10110100, 10110101, 01010100}. imm19=[23:5], sign-extended, then <<2.
  - D: [31:21] in {11111000010, 11111000000}. imm9=[20:12], sign-extended.
  - I: [31:22] in {1001000100, 1011000100, 1101000100, 1111000100, 1001001000, 1011001000, 1101001000}. imm12=[21:10], zero-extended.
  - SHIFT: [31:21] in {11010011011, 11010011010}. shamt=[15:10], zero-extended.
  - Otherwise: FMT_NONE, imm=0.
- Transfers: an input transfer occurs when in_valid and in_ready are both 1. An output transfer occurs when out_valid and out_ready are both 1.
- Latency: 1 cycle. Input accepted at edge N appears on out_* after edge N when the output register was empty or is being drained that same cycle.
- Output register update:
  - Empty, or drained this cycle: loads the skid entry if the skid is occupied, else the decoded input if an input transfer occurs.
  - Occupied and not drained: holds, stable. out_imm, out_fmt and out_valid must not change while out_valid=1 and out_ready=0.
- Skid: captures the decoded input when an input transfer occurs while the output register is occupied and not drained. in_ready = !skid_full, driven from a register only (no combinational path from out_ready).
- Order: strict FIFO, output then skid. No reordering, no duplication, no drops except on flush.
- Simultaneous drain and input with the skid full: the output register takes the skid entry. in_ready is already 0, so no input is taken.
- Flush: at the next edge, out_valid=0, skid empty, in_ready=1. Any input transfer in the same cycle as flush is discarded. Flush has priority over all transfers. out_imm and out_fmt may retain stale values while out_valid=0.
- Reset asserted mid-operation: immediately returns to the reset state, and in-flight entries are lost.
- Width rules: sign extension replicates the field MSB before the shift. The <<2 shift is applied within 64 bits, and bits shifted past bit 63 are discarded.

Decomposition:
- Package imm_pkg holds:
  - typedef enum logic [2:0] imm_fmt_t {FMT_NONE, FMT_I, FMT_D, FMT_CB, FMT_B, FMT_SHIFT}.
  - Localparam opcode constants for every opcode listed above.
  - DATA_W.
- One combinational sub-module, imm_decode (in_instr -> imm, fmt).
- imm_stage holds only the output register, the skid entry and the handshake logic.

Test Plan:
- ADDI in_instr=0x913FFC41, out_ready=1 -> next cycle out_imm=0x0000000000000FFF, out_fmt=FMT_I, out_valid=1.
- LDUR in_instr=0xF85F8020 -> out_imm=0xFFFFFFFFFFFFFFF8 (FMT_D). B in_instr=0x17FFFFFF -> out_imm=0xFFFFFFFFFFFFFFFC (FMT_B). CBZ in_instr=0xB4000020 -> out_imm=0x4 (FMT_CB). in_instr=0x00000000 -> FMT_NONE, imm=0.
- Backpressure: send 3 back-to-back valids with out_ready=0. Required: first held stable on out_*, second in skid, in_ready=0 after the second transfer, third stalls upstream. Then raise out_ready and require delivery in order 1, 2, 3 over consecutive cycles with no gaps.
- Flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1. The following single input then appears alone one cycle later.
- Assert reset low mid-stream with both entries occupied -> out_valid=0, out_imm=0, in_ready=1 without a clock edge. On release, normal 1-cycle latency resumes.
- Random in_valid/out_ready streams (≥10k cycles) checked against a reference FIFO-of-decodes scoreboard. Output stability under stall asserted every cycle.
